// File: rtl/serial_adder_pkg.sv
// serial_adder shared types and defaults.
// State encoding and default operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder request/result bundle.
// master drives operands and start; slave returns the result.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, a, b,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, carry_out
  );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder from two half adders.
// Carries of both halves merge through an OR.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s0),
    .c_o (c0)
  );

  half_adder u_ha1 (
    .a_i (s0),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (c1)
  );

  assign c_o = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder.
// Purely combinational building block.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first, one bit per clock.
// Result and carry publish only on the last bit, with a done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  serial_adder_if.slave    bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             co_q, co_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] s_next;

  full_adder u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (c_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // New bit enters at the MSB so bit 0 ends up at the LSB.
  assign s_next = WIDTH'({fa_s, s_sh_q} >> 1);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    co_d    = co_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        s_sh_d = s_next;
        c_d    = fa_c;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = s_next;
          co_d    = fa_c;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      co_q    <= co_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = co_q;

endmodule
